// File: rtl/multi_chan_arb_dut.sv
// -----------------------------------------------------------------------------
// multi_chan_arb_dut
//   N-channel ready/valid merge. Each input channel has its own FIFO. An arbiter
//   (round-robin or fixed priority) drains the FIFOs into a single registered
//   output stream. Each output word is tagged with its source channel.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active high
//   in_valid    per-channel valid                      [NUM_CHAN]
//   in_ready    per-channel ready (FIFO not full)      [NUM_CHAN]
//   in_data     channel c at [c*DATA_W +: DATA_W]      [NUM_CHAN*DATA_W]
//   out_valid   output word valid
//   out_ready   downstream ready
//   out_data    output word                            [DATA_W]
//   out_chan    source channel of out_data             [$clog2(NUM_CHAN)]
//   fifo_level  per-channel occupancy, packed like in_data
// -----------------------------------------------------------------------------
module multi_chan_arb_dut #(
   parameter int NUM_CHAN   = 4,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int ARB_MODE   = 0
) (
   input  logic                                       clk,
   input  logic                                       rst,
   input  logic [NUM_CHAN-1:0]                        in_valid,
   output logic [NUM_CHAN-1:0]                        in_ready,
   input  logic [NUM_CHAN*DATA_W-1:0]                 in_data,
   output logic                                       out_valid,
   input  logic                                       out_ready,
   output logic [DATA_W-1:0]                          out_data,
   output logic [$clog2(NUM_CHAN)-1:0]                out_chan,
   output logic [NUM_CHAN*($clog2(FIFO_DEPTH)+1)-1:0] fifo_level
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int CHAN_W = $clog2(NUM_CHAN);
   localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [CHAN_W-1:0] LAST_CHAN = CHAN_W'(NUM_CHAN - 1);

   // FIFO storage and bookkeeping
   logic [DATA_W-1:0] mem_q    [NUM_CHAN][FIFO_DEPTH];
   logic [DATA_W-1:0] mem_d    [NUM_CHAN][FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q [NUM_CHAN];
   logic [PTR_W-1:0]  wr_ptr_d [NUM_CHAN];
   logic [PTR_W-1:0]  rd_ptr_q [NUM_CHAN];
   logic [PTR_W-1:0]  rd_ptr_d [NUM_CHAN];
   logic [CNT_W-1:0]  count_q  [NUM_CHAN];
   logic [CNT_W-1:0]  count_d  [NUM_CHAN];

   // Output register and arbiter state
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] out_data_q,  out_data_d;
   logic [CHAN_W-1:0] out_chan_q,  out_chan_d;
   logic [CHAN_W-1:0] last_grant_q, last_grant_d;

   // Combinational helpers
   logic [NUM_CHAN-1:0] req;
   logic [NUM_CHAN-1:0] push;
   logic [NUM_CHAN-1:0] pop;
   logic                load;
   logic                grant_vld;
   logic [CHAN_W-1:0]   grant_idx;
   logic [CHAN_W-1:0]   rr_idx;

   // Requests, ready and level decode from registered counts. in_ready is
   // additionally forced low while rst is asserted.
   always_comb begin
      req        = '0;
      in_ready   = '0;
      push       = '0;
      fifo_level = '0;
      for (int unsigned c = 0; c < NUM_CHAN; c++) begin
         req[c]      = (count_q[c] != '0);
         in_ready[c] = ~rst & (count_q[c] != FULL_CNT);
         push[c]     = in_valid[c] & in_ready[c];
         fifo_level[c*CNT_W +: CNT_W] = count_q[c];
      end
   end

   // Arbiter: fixed priority picks the lowest requester; round-robin searches
   // upward starting one past the last granted channel.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      rr_idx    = '0;
      if (ARB_MODE == 1) begin
         for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            if (!grant_vld && req[i]) begin
               grant_vld = 1'b1;
               grant_idx = CHAN_W'(i);
            end
         end
      end else begin
         for (int unsigned k = 0; k < NUM_CHAN; k++) begin
            rr_idx = CHAN_W'((32'(last_grant_q) + 32'd1 + k) % NUM_CHAN);
            if (!grant_vld && req[rr_idx]) begin
               grant_vld = 1'b1;
               grant_idx = rr_idx;
            end
         end
      end
   end

   // Output register loads when empty or when its word leaves this cycle.
   always_comb begin
      load         = ~out_valid_q | out_ready;
      pop          = '0;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_chan_d   = out_chan_q;
      last_grant_d = last_grant_q;
      if (load) begin
         out_valid_d = grant_vld;
         if (grant_vld) begin
            pop[grant_idx] = 1'b1;
            out_data_d     = mem_q[grant_idx][rd_ptr_q[grant_idx]];
            out_chan_d     = grant_idx;
            last_grant_d   = grant_idx;
         end
      end
   end

   // FIFO pointer/count/storage update; push and pop on the same FIFO leave
   // the count unchanged.
   always_comb begin
      mem_d = mem_q;
      for (int unsigned c = 0; c < NUM_CHAN; c++) begin
         wr_ptr_d[c] = wr_ptr_q[c] + PTR_W'(push[c]);
         rd_ptr_d[c] = rd_ptr_q[c] + PTR_W'(pop[c]);
         count_d[c]  = count_q[c] + CNT_W'(push[c]) - CNT_W'(pop[c]);
         if (push[c]) begin
            mem_d[c][wr_ptr_q[c]] = in_data[c*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '{default: '0};
         rd_ptr_q     <= '{default: '0};
         count_q      <= '{default: '0};
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_chan_q   <= '0;
         last_grant_q <= LAST_CHAN;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_chan_q   <= out_chan_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Storage needs no reset: stale entries are unreachable once pointers clear.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_chan  = out_chan_q;

endmodule
